// File: rtl/mul_sequencer.sv
// mul_sequencer: multicycle shift-and-add multiplier controller that borrows the
// shared core ALU for every partial-product addition. Produces the low WIDTH
// bits of SrcA*SrcB plus {N,Z} flags through a start/busy/done handshake.
//
// Handshake: start is sampled only in IDLE; the accepting edge captures SrcA/SrcB
// and raises busy. busy stays high through RUN and DONE, done pulses for exactly
// one cycle in DONE with Product/NZ valid, and start during busy is ignored.
//
// Optional build macro: MUL_EARLY_TERM_EN -- when defined, RUN also exits as soon
// as the remaining multiplier bits are all zero; results are identical.
//
// Debug: dbg_state exposes the FSM state encoding (0=IDLE, 1=RUN, 2=DONE).

module mul_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Product,
  output logic [1:0]       NZ,
  output logic             AluSel,
  output logic [WIDTH-1:0] AluA,
  output logic [WIDTH-1:0] AluB,
  output logic [1:0]       AluControl,
  input  logic [WIDTH-1:0] AluResult,
  input  logic [3:0]       AluFlags,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] p;       // partial-product accumulator
  logic [WIDTH-1:0] m;       // multiplicand, shifted left each iteration
  logic [WIDTH-1:0] q;       // multiplier, shifted right each iteration
  logic [CNTW-1:0]  count;   // iterations already performed

  logic [WIDTH-1:0] p_next;
  logic [WIDTH-1:0] q_shift;
  logic             last_iter;

  // Flags come from the loaded Product, never from the ALU, so the ALU's flag
  // outputs are intentionally not consumed here.
  logic             alu_flags_unused;
  assign alu_flags_unused = ^AluFlags;

  // Per-iteration datapath values and loop-exit decision
  always_comb begin
    p_next    = q[0] ? AluResult : p;
    q_shift   = q >> 1;
    last_iter = (count == CNTW'(WIDTH - 1));
`ifdef MUL_EARLY_TERM_EN
    if (q_shift == '0) begin
      last_iter = 1'b1;
    end
`endif
  end

  // Next-state and handshake/ALU-request outputs
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    AluSel     = 1'b0;
    AluA       = '0;
    AluB       = '0;
    AluControl = 2'b00;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        busy   = 1'b1;
        AluSel = 1'b1;
        AluA   = p;
        AluB   = m;
        if (last_iter) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign dbg_state = state;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand capture, shift-and-add iteration and result load
  always_ff @(posedge clk) begin
    if (reset) begin
      p       <= '0;
      m       <= '0;
      q       <= '0;
      count   <= '0;
      Product <= '0;
      NZ      <= 2'b01;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            p     <= '0;
            m     <= SrcA;
            q     <= SrcB;
            count <= '0;
          end
        end
        S_RUN: begin
          p     <= p_next;
          m     <= m << 1;
          q     <= q_shift;
          count <= count + CNTW'(1);
          if (last_iter) begin
            Product <= p_next;
            NZ      <= {p_next[WIDTH-1], (p_next == '0)};
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: directed bench for mul_sequencer with a result scoreboard.
// Drivers push {NZ, Product} and the expected done cycle into queues when they
// issue a start; a monitor pops and compares whenever done is seen.
// Honours MUL_EARLY_TERM_EN for the expected latency and extra vectors.

module tb_mul_sequencer;

  localparam int WIDTH = 32;

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product;
  logic [1:0]       nz;
  logic             alu_sel;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [1:0]       alu_control;
  logic [WIDTH-1:0] alu_result;
  logic [3:0]       alu_flags;
  logic [1:0]       dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [WIDTH+1:0] exp_q[$];     // {NZ, Product}
  int               exp_cyc_q[$]; // cycle count at which done must be seen

  mul_sequencer #(.WIDTH(WIDTH), .CNTW(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .SrcA       (src_a),
    .SrcB       (src_b),
    .busy       (busy),
    .done       (done),
    .Product    (product),
    .NZ         (nz),
    .AluSel     (alu_sel),
    .AluA       (alu_a),
    .AluB       (alu_b),
    .AluControl (alu_control),
    .AluResult  (alu_result),
    .AluFlags   (alu_flags),
    .dbg_state  (dbg_state)
  );

  // Behavioural core ALU (add only): the sequencer borrows it for each addition
  assign alu_result = alu_a + alu_b;
  assign alu_flags  = {alu_result[WIDTH-1], (alu_result == '0), 1'b0, 1'b0};

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Expected latency in edges, counting the start-accepting edge
  function automatic int exp_lat(input logic [WIDTH-1:0] b);
`ifdef MUL_EARLY_TERM_EN
    int h;
    h = 0;
    for (int i = 0; i < WIDTH; i++) if (b[i]) h = i;
    return h + 2;
`else
    return WIDTH + 1;
`endif
  endfunction

  // Monitor: compare every done pulse against the scoreboard head
  always @(negedge clk) begin
    logic [WIDTH+1:0] e;
    int               ec;
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
      end else begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("product", 64'(product), 64'(e[WIDTH-1:0]));
        check("nz", 64'(nz), 64'(e[WIDTH+1:WIDTH]));
        check("done_cycle", 64'(cyc), 64'(ec));
        check("busy_in_done", 64'(busy), 64'd1);
      end
    end
  end

  // Drive one start pulse at a negedge and register its expected result
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] exp_p, input logic [1:0] exp_nz);
    start = 1'b1;
    src_a = a;
    src_b = b;
    exp_q.push_back({exp_nz, exp_p});
    exp_cyc_q.push_back(cyc + exp_lat(b));
  endtask

  // Full transaction: start, count AluSel cycles, wait for done, check hold
  task automatic run_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] exp_p, input logic [1:0] exp_nz);
    int sel_n;
    int k;
    bit seen;
    sel_n = 0;
    seen  = 1'b0;
    issue(a, b, exp_p, exp_nz);
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      start = 1'b0;
      src_a = $urandom;
      src_b = $urandom;
      if (alu_sel) sel_n++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", 64'(seen), 64'd1);
    check("alusel_cycles", 64'(sel_n), 64'(exp_lat(b) - 1));
    repeat (2) @(negedge clk);
    check("product_hold", 64'(product), 64'(exp_p));
    check("idle_alu_b", 64'(alu_b), 64'd0);
  endtask

  // Stimulus
  initial begin
    int  inj;
    bit  busy_ok;
    bit  seen;
    reset = 1'b1;
    start = 1'b0;
    src_a = '0;
    src_b = '0;
    repeat (3) @(negedge clk);

    // Reset state, with start asserted to confirm reset wins
    start = 1'b1;
    src_a = 32'd3;
    src_b = 32'd5;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_alusel", 64'(alu_sel), 64'd0);
    check("rst_alu_a", 64'(alu_a), 64'd0);
    check("rst_alu_b", 64'(alu_b), 64'd0);
    check("rst_aluctl", 64'(alu_control), 64'd0);
    check("rst_product", 64'(product), 64'd0);
    check("rst_nz", 64'(nz), 64'd1);
    check("rst_state", 64'(dbg_state), 64'd0);
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("idle_after_rst", 64'(busy), 64'd0);

    // Directed products
    run_mul(32'd3, 32'd5, 32'd15, 2'b00);
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 2'b00);
    run_mul(32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 2'b01);
    run_mul(32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 2'b10);
    run_mul(32'd3, 32'h8000_0000, 32'h8000_0000, 2'b10);
    run_mul(32'd5, 32'd0, 32'd0, 2'b01);
    run_mul(32'd7, 32'd6, 32'd42, 2'b00);
    run_mul(32'd1, 32'd1, 32'd1, 2'b00);

    // Start while busy is ignored; busy must stay high until done
`ifdef MUL_EARLY_TERM_EN
    inj = 2;
`else
    inj = 9;
`endif
    busy_ok = 1'b1;
    seen    = 1'b0;
    issue(32'd7, 32'd9, 32'd63, 2'b00);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      start = (k == inj);
      src_a = (k == inj) ? 32'd2 : 32'd0;
      src_b = (k == inj) ? 32'd2 : 32'd0;
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b0;
    check("ignored_start_done", 64'(seen), 64'd1);
    check("busy_held", 64'(busy_ok), 64'd1);
    repeat (40) @(negedge clk);
    check("no_second_result", 64'(busy), 64'd0);

    // Reset mid-RUN: back to IDLE, results cleared, no done pulse
`ifdef MUL_EARLY_TERM_EN
    inj = 2;
`else
    inj = 11;
`endif
    start = 1'b1;
    src_a = 32'd7;
    src_b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (inj - 1) @(negedge clk);
    check("pre_reset_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_alusel", 64'(alu_sel), 64'd0);
    check("mid_rst_product", 64'(product), 64'd0);
    check("mid_rst_nz", 64'(nz), 64'd1);
    check("mid_rst_alu_a", 64'(alu_a), 64'd0);
    repeat (40) @(negedge clk);
    check("no_done_after_rst", 64'(busy), 64'd0);

    run_mul(32'd4, 32'd4, 32'd16, 2'b00);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
- Multicycle controller that computes a 32-bit ARM MUL/MULS low-word product by shift-and-add.
- Every addition is performed on the shared core ALU, not on a private adder.
- Sits beside the datapath; while it runs, it raises AluSel so the top-level operand mux gives the ALU to the sequencer.
- Returns the product and N/Z flags to the register-writeback and flag logic with a start/busy/done handshake.

Parameters:
WIDTH, 32, operand/product width; iteration count equals WIDTH
CNTW, 6, iteration counter width; must satisfy 2^CNTW > WIDTH

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state on the next clk edge
start  input  1  request a multiply; sampled only in IDLE
SrcA  input  WIDTH  multiplicand, captured on the accepted-start edge
SrcB  input  WIDTH  multiplier, captured on the accepted-start edge
busy  output  1  high in RUN and DONE
done  output  1  single-cycle pulse in DONE; Product/NZ valid in that cycle
Product  output  WIDTH  low WIDTH bits of SrcA*SrcB; held until the next accepted start
NZ  output  2  {N,Z} of Product; held with Product
AluSel  output  1  high only in RUN; top level routes AluA/AluB/AluControl to the ALU
AluA  output  WIDTH  partial-product accumulator P
AluB  output  WIDTH  shifted multiplicand M
AluControl  output  2  fixed 2'b00 (add)
AluResult  input  WIDTH  ALU Result, combinational from AluA+AluB
AluFlags  input  4  ALU {N,Z,C,V}; C and V are ignored

Behaviour:
- Reset values: state=IDLE; P, M, Q, count, Product = 0; NZ=2'b01; busy, done, AluSel = 0; AluA, AluB = 0; AluControl=2'b00.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1: P<=0, M<=SrcA, Q<=SrcB, count<=0, go RUN. start=0: stay in IDLE.
- RUN, each edge:
  - if Q[0]=1, P<=AluResult; else P holds.
  - M<=M<<1, Q<=Q>>1 (zero fill), count<=count+1.
  - when count==WIDTH-1 on this edge, go DONE and load Product<=next P and NZ<={next P[WIDTH-1], next P==0}.
- DONE: done=1 for exactly one cycle, then IDLE. No start is accepted in DONE.
- Latency: start sampled at edge E0; iterations occur at E1..E32; done is high between E32 and E33. Total 33 cycles from start to done, WIDTH=32.
- start while busy is ignored; SrcA/SrcB are not re-captured.
- Arithmetic: modulo 2^WIDTH; ALU carry-out and V are discarded. Signed and unsigned operands yield the same low word.
- NZ is derived from the loaded Product, not from AluFlags, so non-add cycles cannot corrupt it.
- AluA/AluB are driven from P/M only when AluSel=1; otherwise they are driven to 0.
- reset mid-RUN or in DONE: return to IDLE next edge with reset values; no done pulse. Product is cleared.
- reset and start in the same cycle: reset wins.

Optional Feature:
- Macro MUL_EARLY_TERM_EN.
- Defined: RUN also exits to DONE on the edge where next Q==0, i.e. all remaining multiplier bits are zero. Latency becomes 1+(index of highest set bit of SrcB)+1 cycles.
  - SrcB=0: one RUN iteration; done high in cycle 2 after start.
  - SrcB=1: done in cycle 2.
  - SrcB=0x80000000: done in cycle 33.
  - Product and NZ are identical to the non-terminating build.
- Undefined: fixed WIDTH iterations regardless of operands.

Test Plan:
- SrcA=3, SrcB=5, start pulse -> done in cycle 33, Product=15, NZ=2'b00, AluSel high during cycles 1..32 only.
- SrcA=0xFFFFFFFF, SrcB=0xFFFFFFFF -> Product=0x00000001, NZ=2'b00.
- SrcA=0x00010000, SrcB=0x00010000 -> Product=0, NZ=2'b01. Second case SrcA=0xFFFFFFFF, SrcB=2 -> Product=0xFFFFFFFE, NZ=2'b10.
- Start 7*9, pulse start again with 2*2 at cycle 10 -> second start ignored; Product=63 at cycle 33; busy stays high throughout.
- Start 7*9, assert reset at cycle 12 -> IDLE next edge, no done pulse, Product=0, NZ=2'b01. A new 4*4 afterwards gives 16 after full latency.
- MUL_EARLY_TERM_EN defined:
  - SrcB=0 -> done at cycle 2, Product=0.
  - SrcB=6, SrcA=7 -> done at cycle 4, Product=42.
